// File: rtl/modulo_escalonador_rolhas.sv
// Cork buffer scheduler: secondary/principal buffers, sealer/refill/load arbitration.
// Ports: clk, clr (async active-low), enable, seal_req, load_req, load_qty[6:0] in;
//   load_ready, load_reject, sec_count[6:0], princ_count[4:0], state[1:0], ro, seal_miss out.
// Build option ROLHAS_LOAD_SATURATE_EN: clip over-capacity loads instead of refusing them.
module modulo_escalonador_rolhas #(
  parameter int SEC_MAX       = 99,
  parameter int TRANSFER_QTY  = 20,
  parameter int MIN_PRINCIPAL = 5
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       enable,
  input  logic       seal_req,
  input  logic       load_req,
  input  logic [6:0] load_qty,
  output logic       load_ready,
  output logic       load_reject,
  output logic [6:0] sec_count,
  output logic [4:0] princ_count,
  output logic [1:0] state,
  output logic       ro,
  output logic       seal_miss
);

  localparam logic [6:0] SecMax   = 7'(SEC_MAX);
  localparam logic [6:0] XferQty7 = 7'(TRANSFER_QTY);
  localparam logic [4:0] XferQty5 = 5'(TRANSFER_QTY);
  localparam logic [4:0] MinPrinc = 5'(MIN_PRINCIPAL);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    XFER = 2'b01,
    LOAD = 2'b10
  } st_e;

  st_e        state_q, state_d;
  logic [6:0] sec_q, sec_d;
  logic [4:0] princ_q, princ_d;
  logic [4:0] xrem_q, xrem_d;
  logic [6:0] lrem_q, lrem_d;
  logic       miss_q, miss_d;
  logic       rej_q, rej_d;

  logic       seal_ok;
  logic       xfer_step;
  logic       load_step;
  logic       refill_ok;
  logic       load_acc;
  logic       over;
  logic [7:0] sum;
  logic [6:0] room;
  logic [6:0] acc_qty;

  // A seal that actually removes a cork stalls the transfer that cycle.
  assign seal_ok   = seal_req && (princ_q != 5'd0);
  assign xfer_step = enable && (state_q == XFER) && !seal_ok;
  assign load_step = enable && (state_q == LOAD);
  assign refill_ok = (princ_q < MinPrinc) && (sec_q >= XferQty7);
  // lrem_q doubles as the pending-load latch: nonzero means busy.
  assign load_acc  = load_req && (lrem_q == 7'd0);
  assign sum       = {1'b0, sec_q} + {1'b0, load_qty};
  assign over      = sum > {1'b0, SecMax};
  assign room      = SecMax - sec_q;

`ifdef ROLHAS_LOAD_SATURATE_EN
  assign acc_qty = over ? room : load_qty;
`else
  assign acc_qty = over ? 7'd0 : load_qty;
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (enable) begin
      unique case (state_q)
        IDLE: begin
          if (refill_ok) state_d = XFER;
          else if (lrem_q != 7'd0) state_d = LOAD;
        end
        XFER: if (xfer_step && xrem_q == 5'd1) state_d = IDLE;
        LOAD: if (lrem_q == 7'd1) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    state       = state_q;
    sec_count   = sec_q;
    princ_count = princ_q;
    ro          = (princ_q == 5'd0);
    load_ready  = (lrem_q == 7'd0);
    load_reject = rej_q;
    seal_miss   = miss_q;
  end

  always_comb begin
    sec_d   = sec_q;
    princ_d = princ_q;
    xrem_d  = xrem_q;
    lrem_d  = lrem_q;
    miss_d  = seal_req && (princ_q == 5'd0);
    rej_d   = load_acc && over;
    if (seal_ok) princ_d = princ_q - 5'd1;
    if (xfer_step) begin
      sec_d   = sec_q - 7'd1;
      princ_d = princ_q + 5'd1;
      xrem_d  = xrem_q - 5'd1;
    end
    if (load_step) begin
      sec_d  = sec_q + 7'd1;
      lrem_d = lrem_q - 7'd1;
    end
    if (enable && state_q == IDLE && refill_ok) xrem_d = XferQty5;
    if (load_acc) lrem_d = acc_qty;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sec_q   <= 7'd0;
      princ_q <= 5'd0;
      xrem_q  <= 5'd0;
      lrem_q  <= 7'd0;
      miss_q  <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      sec_q   <= sec_d;
      princ_q <= princ_d;
      xrem_q  <= xrem_d;
      lrem_q  <= lrem_d;
      miss_q  <= miss_d;
      rej_q   <= rej_d;
    end
  end

endmodule

// File: tb/tb_modulo_escalonador_rolhas.sv
// Directed scoreboard bench for modulo_escalonador_rolhas.
// Honours ROLHAS_LOAD_SATURATE_EN for the over-capacity expectations.
module tb_modulo_escalonador_rolhas;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       enable = 1'b0;
  logic       seal_req = 1'b0;
  logic       load_req = 1'b0;
  logic [6:0] load_qty = 7'd0;
  logic       load_ready;
  logic       load_reject;
  logic [6:0] sec_count;
  logic [4:0] princ_count;
  logic [1:0] state;
  logic       ro;
  logic       seal_miss;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int sec;
    int princ;
  } exp_t;
  exp_t sb[$];

`ifdef ROLHAS_LOAD_SATURATE_EN
  localparam int SAT = 1;
`else
  localparam int SAT = 0;
`endif
  localparam int S = (SAT != 0) ? 99 : 90;
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_XFER = 2'b01;
  localparam logic [1:0] ST_LOAD = 2'b10;

  always #5 clk = ~clk;

  modulo_escalonador_rolhas dut (
    .clk        (clk),
    .clr        (clr),
    .enable     (enable),
    .seal_req   (seal_req),
    .load_req   (load_req),
    .load_qty   (load_qty),
    .load_ready (load_ready),
    .load_reject(load_reject),
    .sec_count  (sec_count),
    .princ_count(princ_count),
    .state      (state),
    .ro         (ro),
    .seal_miss  (seal_miss)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int s, input int p);
    exp_t e;
    e.sec = s;
    e.princ = p;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    chk({tag, "_sb_has"}, 32'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_sec"}, 32'(sec_count), e.sec);
      chk({tag, "_princ"}, 32'(princ_count), e.princ);
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input string tag);
    int n = 0;
    while (state !== s && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_reach"}, 32'(state), 32'(s));
  endtask

  task automatic run_len(input logic [1:0] s, output int n);
    n = 0;
    while (state === s && n < 300) begin
      n++;
      tick();
    end
  endtask

  task automatic load(input int q);
    load_qty = 7'(q);
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic seals(input int k);
    seal_req = 1'b1;
    repeat (k) tick();
    seal_req = 1'b0;
  endtask

  initial begin
    int n;
    clr = 1'b0;
    enable = 1'b1;
    #12;
    chk("rst_state", 32'(state), 0);
    chk("rst_sec", 32'(sec_count), 0);
    chk("rst_princ", 32'(princ_count), 0);
    chk("rst_ready", 32'(load_ready), 1);
    chk("rst_ro", 32'(ro), 1);
    chk("rst_miss", 32'(seal_miss), 0);
    chk("rst_rej", 32'(load_reject), 0);
    @(negedge clk);
    clr = 1'b1;
    tick();

    seal_req = 1'b1;
    tick();
    seal_req = 1'b0;
    chk("miss_pulse", 32'(seal_miss), 1);
    chk("miss_princ", 32'(princ_count), 0);
    chk("miss_sec", 32'(sec_count), 0);
    chk("miss_ro", 32'(ro), 1);
    tick();
    chk("miss_clear", 32'(seal_miss), 0);

    load(30);
    push(30, 0);
    chk("l30_ready", 32'(load_ready), 0);
    chk("l30_idle", 32'(state), 32'(ST_IDLE));
    wait_state(ST_LOAD, "l30");
    run_len(ST_LOAD, n);
    chk("l30_len", n, 30);
    pop_cmp("l30");
    chk("l30_ready_back", 32'(load_ready), 1);
    push(10, 20);
    wait_state(ST_XFER, "x1");
    run_len(ST_XFER, n);
    chk("x1_len", n, 20);
    pop_cmp("x1");
    chk("x1_ro", 32'(ro), 0);

    load(40);
    push(50, 20);
    wait_state(ST_LOAD, "l40");
    run_len(ST_LOAD, n);
    chk("l40_len", n, 40);
    pop_cmp("l40");
    seals(16);
    chk("p4_princ", 32'(princ_count), 4);
    push(30, 23);
    wait_state(ST_XFER, "stall");
    n = 0;
    while (state === ST_XFER && n < 300) begin
      n++;
      seal_req = (n == 3);
      tick();
    end
    seal_req = 1'b0;
    chk("stall_len", n, 21);
    pop_cmp("stall");

    seal_req = 1'b1;
    repeat (18) tick();
    load_qty = 7'd10;
    load_req = 1'b1;
    tick();
    seal_req = 1'b0;
    load_req = 1'b0;
    chk("pend_princ", 32'(princ_count), 4);
    chk("pend_ready", 32'(load_ready), 0);
    push(20, 24);
    wait_state(ST_XFER, "pend_x");
    run_len(ST_XFER, n);
    chk("pend_x_len", n, 20);
    chk("pend_x_ready", 32'(load_ready), 0);
    wait_state(ST_LOAD, "pend_l");
    run_len(ST_LOAD, n);
    chk("pend_l_len", n, 10);
    chk("pend_l_ready", 32'(load_ready), 1);
    pop_cmp("pend");

    load(70);
    push(90, 24);
    wait_state(ST_LOAD, "l70");
    run_len(ST_LOAD, n);
    chk("l70_len", n, 70);
    pop_cmp("l70");
    load_qty = 7'd15;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    chk("rej_pulse", 32'(load_reject), 1);
    chk("rej_ready", 32'(load_ready), (SAT != 0) ? 0 : 1);
    tick();
    chk("rej_clear", 32'(load_reject), 0);
    push(S, 24);
    n = 0;
    while (!(state === ST_IDLE && load_ready === 1'b1) && n < 300) begin
      tick();
      n++;
    end
    chk("rej_idle", 32'(n < 300), 1);
    pop_cmp("rej");
    load(0);
    chk("zero_ready", 32'(load_ready), 1);
    chk("zero_rej", 32'(load_reject), 0);
    chk("zero_sec", 32'(sec_count), S);

    seals(20);
    push(S - 20, 24);
    wait_state(ST_XFER, "x3");
    run_len(ST_XFER, n);
    chk("x3_len", n, 20);
    pop_cmp("x3");
    load(9);
    push(S - 11, 23);
    wait_state(ST_LOAD, "frz");
    repeat (3) tick();
    enable = 1'b0;
    seal_req = 1'b1;
    tick();
    seal_req = 1'b0;
    repeat (4) tick();
    chk("frz_state", 32'(state), 32'(ST_LOAD));
    chk("frz_sec", 32'(sec_count), S - 17);
    chk("frz_princ", 32'(princ_count), 23);
    chk("frz_ready", 32'(load_ready), 0);
    enable = 1'b1;
    run_len(ST_LOAD, n);
    chk("frz_rest_len", n, 6);
    pop_cmp("frz");

    seals(19);
    wait_state(ST_XFER, "rx");
    repeat (5) tick();
    #2;
    clr = 1'b0;
    #1;
    chk("mrst_state", 32'(state), 0);
    chk("mrst_sec", 32'(sec_count), 0);
    chk("mrst_princ", 32'(princ_count), 0);
    chk("mrst_ro", 32'(ro), 1);
    chk("mrst_ready", 32'(load_ready), 1);
    @(negedge clk);
    clr = 1'b1;
    tick();
    chk("post_state", 32'(state), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
